// File: rtl/bnn_loader_pkg.sv
// Shared types and default geometry for the BNN feature loader.
package bnn_loader_pkg;

  // Loader control states
  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } loader_state_t;

  localparam int DEF_FEAT_CNT  = 16;
  localparam int DEF_FEAT_BITS = 4;
  localparam int DEF_CLASS_CNT = 10;

endpackage

// File: rtl/bnn_feature_loader.sv
// Streams feature words into a packed vector for a combinational classifier,
// waits for it to settle, and registers the predicted class for a
// valid/ready consumer. Optional inference counter under BNN_LOADER_COUNT_EN.
module bnn_feature_loader
  import bnn_loader_pkg::*;
#(
  parameter int FEAT_CNT   = DEF_FEAT_CNT,
  parameter int FEAT_BITS  = DEF_FEAT_BITS,
  parameter int CLASS_CNT  = DEF_CLASS_CNT,
  parameter int SETTLE_CYC = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            s_valid,
  input  logic [FEAT_BITS-1:0]            s_data,
  input  logic                            s_last,
  output logic                            s_ready,
  output logic [FEAT_CNT*FEAT_BITS-1:0]   features,
  input  logic [$clog2(CLASS_CNT)-1:0]    prediction,
  output logic                            m_valid,
  output logic [$clog2(CLASS_CNT)-1:0]    m_class,
  input  logic                            m_ready,
  output logic                            frame_err
`ifdef BNN_LOADER_COUNT_EN
  ,
  output logic [15:0]                     inf_count
`endif
);

  localparam int CW = $clog2(CLASS_CNT);
  localparam int IW = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;

  loader_state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [3:0]    cnt, cnt_n;
  logic          err_n;
  logic          wr_en;
  logic          capture;
  logic          release_res;
  logic          last_slot;

  assign last_slot = (idx == IW'(FEAT_CNT - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_n;
  end

  // Next-state, counters and handshake decode
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    cnt_n       = cnt;
    err_n       = 1'b0;
    wr_en       = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    s_ready     = 1'b0;
    case (state)
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          wr_en = 1'b1;
          if (s_last && last_slot) begin
            state_n = SETTLE;
            idx_n   = '0;
            cnt_n   = 4'(SETTLE_CYC);
          end else if (s_last || last_slot) begin
            err_n = 1'b1;
            idx_n = '0;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          capture = 1'b1;
          state_n = HOLD;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      HOLD: begin
        if (m_ready) begin
          release_res = 1'b1;
          state_n     = LOAD;
        end
      end
      default: state_n = LOAD;
    endcase
  end

  // Word counter, settle counter and drop-pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      cnt       <= '0;
      frame_err <= 1'b0;
    end else begin
      idx       <= idx_n;
      cnt       <= cnt_n;
      frame_err <= err_n;
    end
  end

  // Feature store: word k lands in the k-th slot from the MSB end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      features <= '0;
    end else if (wr_en) begin
      features[(FEAT_CNT - 1 - int'(idx)) * FEAT_BITS +: FEAT_BITS] <= s_data;
    end
  end

  // Result register held until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_class <= '0;
    end else if (capture) begin
      m_valid <= 1'b1;
      m_class <= prediction;
    end else if (release_res) begin
      m_valid <= 1'b0;
    end
  end

`ifdef BNN_LOADER_COUNT_EN
  logic [15:0] inf_cnt_q;

  // Completed-inference counter, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           inf_cnt_q <= '0;
    else if (release_res) inf_cnt_q <= inf_cnt_q + 16'd1;
  end

  assign inf_count = inf_cnt_q;
`endif

  logic unused_cw;
  assign unused_cw = (CW == 0);

endmodule

// File: doc/bnn_feature_loader.md
BNN_FEATURE_LOADER -- requirements
Module: bnn_feature_loader

Interface
REQ-001 SHALL have parameter FEAT_CNT, default 16, number of features per frame.
REQ-002 SHALL have parameter FEAT_BITS, default 4, bits per feature.
REQ-003 SHALL have parameter CLASS_CNT, default 10, number of classes; CW = $clog2(CLASS_CNT).
REQ-004 SHALL have parameter SETTLE_CYC, default 1, range 1..15, cycles allowed for the combinational classifier to settle.
REQ-005 SHALL have port clk, input, 1, the single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port s_valid, input, 1, feature word valid.
REQ-008 SHALL have port s_data, input, FEAT_BITS, feature word.
REQ-009 SHALL have port s_last, input, 1, marks the final word of a frame.
REQ-010 SHALL have port s_ready, output, 1, loader accepts a word.
REQ-011 SHALL have port features, output, FEAT_CNT*FEAT_BITS, packed vector driven to the classifier.
REQ-012 SHALL have port prediction, input, CW, classifier result.
REQ-013 SHALL have port m_valid, output, 1, result valid.
REQ-014 SHALL have port m_class, output, CW, registered class.
REQ-015 SHALL have port m_ready, input, 1, consumer accepts the result.
REQ-016 SHALL have port frame_err, output, 1, one-cycle pulse on a dropped frame.

Function
REQ-017 SHALL implement FSM states LOAD, SETTLE, HOLD.
REQ-018 In LOAD, s_ready SHALL be 1; each s_valid&&s_ready beat writes s_data to slot idx and increments a word counter idx.
REQ-019 Word k of a frame SHALL land in features[(FEAT_CNT-1-k)*FEAT_BITS +: FEAT_BITS] (first word in the MSBs, matching the hex test-vector file layout).
REQ-020 Accepting word idx==FEAT_CNT-1 with s_last=1 SHALL move to SETTLE, clear idx, and load the settle counter with SETTLE_CYC.
REQ-021 s_last=1 with idx<FEAT_CNT-1, or s_last=0 with idx==FEAT_CNT-1, SHALL drop the frame: pulse frame_err for one cycle, clear idx, stay in LOAD.
REQ-022 features SHALL change only on accepted beats; it stays stable through SETTLE and HOLD.
REQ-023 In SETTLE, s_ready SHALL be 0; the settle counter decrements each cycle; at 0, prediction is registered into m_class, m_valid goes 1, state becomes HOLD.
REQ-024 Latency from the last accepted beat to m_valid=1 SHALL be exactly SETTLE_CYC+1 cycles.
REQ-025 In HOLD, m_valid and m_class SHALL remain stable until m_valid&&m_ready; on that cycle m_valid drops next edge and state returns to LOAD.
REQ-026 s_ready SHALL be 0 in HOLD; a new frame cannot start until the result is consumed (no overlap, no combinational path m_ready->s_ready).

Reset
REQ-027 On rst_n=0, asynchronously: state=LOAD, idx=0, settle counter=0, features=0, m_class=0, m_valid=0, frame_err=0; s_ready SHALL be 1 after reset release.
REQ-028 Reset asserted mid-frame, mid-SETTLE or in HOLD SHALL discard all partial data and the pending result without emitting frame_err.

Configuration
REQ-029 Macro BNN_LOADER_COUNT_EN defined SHALL add output inf_count, 16 bits, incremented on each m_valid&&m_ready handshake, wrapping 16'hFFFF->0, reset to 0.
REQ-030 Without BNN_LOADER_COUNT_EN the port and counter SHALL not exist; all other behaviour is identical.

Structure
REQ-031 Package bnn_loader_pkg SHALL hold the state enum type (LOAD/SETTLE/HOLD) and default constants for FEAT_CNT, FEAT_BITS, CLASS_CNT.
REQ-032 The module SHALL be flat; no sub-module. The classifier instance (e.g. pendigits_bnn1_bnnpar) SHALL live in the parent, not in the loader.

Verification
REQ-033 Reset then 16 beats 0x0..0xF, s_last on beat 15 -> features=64'h0123456789ABCDEF, m_valid 2 cycles after the last beat (SETTLE_CYC=1), m_class equals the classifier's prediction.
REQ-034 Hold m_ready=0 for 10 cycles after m_valid -> m_valid, m_class, features stable; s_ready=0; beats presented are not accepted.
REQ-035 s_last on beat 5 -> frame_err pulse 1 cycle, idx=0, following full frame classifies correctly.
REQ-036 Beat 15 with s_last=0 -> frame_err pulse, no m_valid; s_valid toggling randomly mid-frame -> same packed result as back-to-back.
REQ-037 Assert rst_n in SETTLE -> m_valid stays 0, s_ready=1 after release, no frame_err.
REQ-038 With BNN_LOADER_COUNT_EN and inf_count preset-equivalent to 16'hFFFF via 65535 frames (or forced) -> next handshake gives inf_count=0.
